// File: rtl/uart_pkg.sv
// Shared types and constants for the uart transmit path.
// The parity helper is only referenced when UART_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [3:0] DATA_BITS_8 = 4'd8;
  localparam logic [3:0] DATA_BITS_7 = 4'd7;
  localparam int         DIV_DEFAULT = 868;

  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and flags the last clock of each bit.
// A synchronous clear holds the count at zero while the sequencer is idle.
import uart_pkg::*;

module uart_baud_gen #(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic arst,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_r;

  assign bit_end = (cnt_r == CW'(DIV - 1));

  // Bit-period counter, wraps on bit_end.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_r <= '0;
    end else if (clr || bit_end) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, 7/8 data bits LSB first, optional parity, stop.
// Optional parity bit is compiled in with the UART_PARITY_EN macro.
import uart_pkg::*;

module uart_tx_ctrl #(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       data_length,
  input  logic       parity_odd,
  output logic       tx,
  output logic       busy
);

  state_t     state_r;
  state_t     next_state_s;
  logic [7:0] shreg_r;
  logic [3:0] nbits_r;
  logic [2:0] bit_idx_r;
  logic       tx_r;
  logic       tx_next_s;
  logic       bit_end_s;
  logic       handshake_s;
  logic       last_bit_s;
  logic [7:0] masked_s;

  assign handshake_s = (state_r == IDLE) && tx_valid;
  assign last_bit_s  = ({1'b0, bit_idx_r} == (nbits_r - 4'd1));
  assign masked_s    = {tx_data[7] & data_length, tx_data[6:0]};
  assign tx_ready    = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign tx          = tx_r;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .arst    (arst),
    .clr     (state_r == IDLE),
    .bit_end (bit_end_s)
  );

`ifdef UART_PARITY_EN
  logic parity_r;

  // Parity is computed once from the masked byte; bit 7 is zero in 7-bit mode.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      parity_r <= 1'b0;
    end else if (handshake_s) begin
      parity_r <= calc_parity(masked_s, parity_odd);
    end else begin
      parity_r <= parity_r;
    end
  end
`else
  logic unused_parity_s;
  assign unused_parity_s = parity_odd;
`endif

  // Next-state and line-level decode; tx is registered from the current state.
  always_comb begin
    next_state_s = state_r;
    tx_next_s    = 1'b1;
    case (state_r)
      IDLE: begin
        tx_next_s = 1'b1;
        if (tx_valid) next_state_s = START;
        else          next_state_s = IDLE;
      end
      START: begin
        tx_next_s = 1'b0;
        if (bit_end_s) next_state_s = DATA;
        else           next_state_s = START;
      end
      DATA: begin
        tx_next_s = shreg_r[0];
        if (bit_end_s && last_bit_s) begin
`ifdef UART_PARITY_EN
          next_state_s = PARITY;
`else
          next_state_s = STOP;
`endif
        end else begin
          next_state_s = DATA;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        tx_next_s = parity_r;
        if (bit_end_s) next_state_s = STOP;
        else           next_state_s = PARITY;
      end
`endif
      STOP: begin
        tx_next_s = 1'b1;
        if (bit_end_s) next_state_s = IDLE;
        else           next_state_s = STOP;
      end
      default: begin
        tx_next_s    = 1'b1;
        next_state_s = IDLE;
      end
    endcase
  end

  // State and serial-line registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r <= IDLE;
      tx_r    <= 1'b1;
    end else begin
      state_r <= next_state_s;
      tx_r    <= tx_next_s;
    end
  end

  // Frame datapath: latch on handshake, shift LSB-first at each data bit end.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      shreg_r   <= 8'h00;
      nbits_r   <= 4'd0;
      bit_idx_r <= 3'd0;
    end else if (handshake_s) begin
      shreg_r   <= masked_s;
      nbits_r   <= data_length ? DATA_BITS_8 : DATA_BITS_7;
      bit_idx_r <= 3'd0;
    end else if ((state_r == DATA) && bit_end_s) begin
      shreg_r   <= {1'b0, shreg_r[7:1]};
      bit_idx_r <= bit_idx_r + 3'd1;
    end else begin
      shreg_r   <= shreg_r;
      bit_idx_r <= bit_idx_r;
    end
  end

endmodule
